// File: rtl/ciphertext_collector_if.sv
// Character stream interface between the encryption stage, the collector and the
// transmit stage. The slave side is the collector.
interface ciphertext_collector_if;
    logic       C_ready;
    logic [7:0] Char_ciphertext;
    logic       err_invalid_ptxt;
    logic       msg_last;
    logic       out_valid;
    logic [7:0] out_char;
    logic       out_last;
    logic       out_ready;

    modport master (
        output C_ready, Char_ciphertext, err_invalid_ptxt, msg_last, out_ready,
        input  out_valid, out_char, out_last
    );

    modport slave (
        input  C_ready, Char_ciphertext, err_invalid_ptxt, msg_last, out_ready,
        output out_valid, out_char, out_last
    );
endinterface

// File: rtl/ciphertext_collector.sv
// First-word-fall-through FIFO for ciphertext characters, with message framing,
// message length tracking and an invalid-plaintext edge counter.
module ciphertext_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    ciphertext_collector_if.slave    bus,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         msg_len,
    output logic                     msg_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_C    = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE_C = CW'(1);
    localparam logic [AW-1:0]    PTR_ONE_C = AW'(1);
    localparam logic [CNT_W-1:0] SAT_C     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LEN_ONE_C = CNT_W'(1);

    typedef enum logic [0:0] {IDLE = 1'b0, COLLECT = 1'b1} state_t;

    logic [8:0]       mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             out_valid_r, out_last_r, overflow_r, msg_done_r, err_prev_r;
    logic [7:0]       out_char_r;
    logic [CNT_W-1:0] msg_len_r, err_cnt_r;
    state_t           state_r;

    logic             rd_s, full_s, wr_acc_s, drop_s;
    logic [CW-1:0]    count_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [8:0]       head_nxt_s;

    // Next FIFO occupancy and the head entry that will be presented after this edge.
    always_comb begin
        rd_s         = out_valid_r & bus.out_ready;
        full_s       = (count_r == FULL_C);
        wr_acc_s     = bus.C_ready & (~full_s | rd_s);
        drop_s       = bus.C_ready & full_s & ~rd_s;
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_s ? (rd_ptr_r + PTR_ONE_C) : rd_ptr_r;
        case ({wr_acc_s, rd_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
        // The written entry becomes the head only when nothing older remains.
        if (count_nxt_s == {CW{1'b0}}) begin
            head_nxt_s = 9'h000;
        end else if (wr_acc_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = {bus.msg_last, bus.Char_ciphertext};
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= 9'h000;
        end else if (!clear && wr_acc_s) begin
            mem_r[wr_ptr_r] <= {bus.msg_last, bus.Char_ciphertext};
        end
    end

    // Pointers, occupancy, sticky overflow and the registered head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            out_last_r  <= 1'b0;
        end else if (clear) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            out_last_r  <= 1'b0;
        end else begin
            if (wr_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            if (drop_s) overflow_r <= 1'b1;
            out_valid_r <= (count_nxt_s != {CW{1'b0}});
            out_char_r  <= head_nxt_s[7:0];
            out_last_r  <= head_nxt_s[8];
        end
    end

    // Message framing FSM; dropped writes still count toward the message.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            msg_len_r  <= {CNT_W{1'b0}};
            msg_done_r <= 1'b0;
        end else if (clear) begin
            state_r    <= IDLE;
            msg_len_r  <= {CNT_W{1'b0}};
            msg_done_r <= 1'b0;
        end else begin
            msg_done_r <= bus.C_ready & bus.msg_last;
            if (bus.C_ready) begin
                case (state_r)
                    IDLE: begin
                        msg_len_r <= LEN_ONE_C;
                        state_r   <= bus.msg_last ? IDLE : COLLECT;
                    end
                    COLLECT: begin
                        if (msg_len_r != SAT_C) msg_len_r <= msg_len_r + LEN_ONE_C;
                        state_r <= bus.msg_last ? IDLE : COLLECT;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // Rising-edge counter of invalid-plaintext events; the edge register ignores clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_prev_r <= 1'b0;
            err_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            err_prev_r <= bus.err_invalid_ptxt;
            if (clear) begin
                err_cnt_r <= {CNT_W{1'b0}};
            end else if (bus.err_invalid_ptxt && !err_prev_r && (err_cnt_r != SAT_C)) begin
                err_cnt_r <= err_cnt_r + LEN_ONE_C;
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_char  = out_char_r;
    assign bus.out_last  = out_last_r;
    assign fifo_count    = count_r;
    assign overflow      = overflow_r;
    assign err_cnt       = err_cnt_r;
    assign msg_len       = msg_len_r;
    assign msg_done      = msg_done_r;
endmodule

// File: tb/tb_ciphertext_collector.sv
// Self-checking bench: directed table, hand-written corner sequences and random
// traffic against a queue-based reference model.
module tb_ciphertext_collector;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [3:0] fifo_count;
    logic       overflow;
    logic [7:0] err_cnt;
    logic [7:0] msg_len;
    logic       msg_done;

    ciphertext_collector_if bus ();

    ciphertext_collector #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .fifo_count(fifo_count), .overflow(overflow), .err_cnt(err_cnt),
        .msg_len(msg_len), .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [8:0] m_q[$];
    logic       m_ovf, m_prev, m_in_msg, m_done;
    int         m_err, m_len;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0; m_prev = 1'b0; m_in_msg = 1'b0; m_done = 1'b0;
        m_err = 0; m_len = 0;
    endtask

    task automatic model_step(input logic wr, input logic [7:0] ch, input logic last,
                              input logic ord, input logic err, input logic clr);
        int  pre;
        logic rd;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0; m_in_msg = 1'b0; m_done = 1'b0; m_err = 0; m_len = 0;
        end else begin
            pre = m_q.size();
            rd  = (pre > 0) && ord;
            if (rd) void'(m_q.pop_front());
            if (wr) begin
                if (pre < DEPTH || rd) m_q.push_back({last, ch});
                else m_ovf = 1'b1;
                m_len    = m_in_msg ? ((m_len < 255) ? m_len + 1 : 255) : 1;
                m_in_msg = !last;
            end
            m_done = wr && last;
            if (err && !m_prev && m_err < 255) m_err++;
        end
        m_prev = err;
    endtask

    task automatic compare_model();
        int n;
        n = m_q.size();
        check("fifo_count", int'(fifo_count), n);
        check("out_valid", int'(bus.out_valid), (n != 0) ? 1 : 0);
        check("out_char", int'(bus.out_char), (n != 0) ? int'(m_q[0][7:0]) : 0);
        check("out_last", int'(bus.out_last), (n != 0) ? int'(m_q[0][8]) : 0);
        check("overflow", int'(overflow), int'(m_ovf));
        check("err_cnt", int'(err_cnt), m_err);
        check("msg_len", int'(msg_len), m_len);
        check("msg_done", int'(msg_done), int'(m_done));
    endtask

    task automatic cycle(input logic wr, input logic [7:0] ch, input logic last,
                         input logic ord, input logic err, input logic clr);
        bus.C_ready = wr; bus.Char_ciphertext = ch; bus.msg_last = last;
        bus.out_ready = ord; bus.err_invalid_ptxt = err; clear = clr;
        @(posedge clk);
        model_step(wr, ch, last, ord, err, clr);
        #1;
        compare_model();
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] ch;
        logic       last, ord, err;
        int         e_cnt;
        logic       e_valid;
        logic [7:0] e_char;
        logic       e_last;
        int         e_len;
        logic       e_done;
        int         e_err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1, 1'b1, 8'h10, 1'b0, 1, 1'b0, 0};
        tbl[1]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 2, 1'b1, 8'h10, 1'b0, 2, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 3, 1'b1, 8'h10, 1'b0, 3, 1'b1, 0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2, 1'b1, 8'h20, 1'b0, 3, 1'b0, 0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b1, 8'h30, 1'b1, 3, 1'b0, 0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 3, 1'b0, 0};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 3, 1'b0, 1};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 3, 1'b0, 1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 3, 1'b0, 1};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 3, 1'b0, 2};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 3, 1'b0, 2};

        rst_n = 1'b0; clear = 1'b0;
        bus.C_ready = 1'b0; bus.Char_ciphertext = 8'h00; bus.msg_last = 1'b0;
        bus.out_ready = 1'b0; bus.err_invalid_ptxt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", int'(fifo_count), 0);
        check("reset_valid", int'(bus.out_valid), 0);
        rst_n = 1'b1;

        // directed table: basic message, FWFT drain and err edge counting
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].wr, tbl[i].ch, tbl[i].last, tbl[i].ord, tbl[i].err, 1'b0);
            check($sformatf("tbl%0d_cnt", i), int'(fifo_count), tbl[i].e_cnt);
            check($sformatf("tbl%0d_valid", i), int'(bus.out_valid), int'(tbl[i].e_valid));
            check($sformatf("tbl%0d_char", i), int'(bus.out_char), int'(tbl[i].e_char));
            check($sformatf("tbl%0d_last", i), int'(bus.out_last), int'(tbl[i].e_last));
            check($sformatf("tbl%0d_len", i), int'(msg_len), tbl[i].e_len);
            check($sformatf("tbl%0d_done", i), int'(msg_done), int'(tbl[i].e_done));
            check($sformatf("tbl%0d_err", i), int'(err_cnt), tbl[i].e_err);
        end

        // overflow: nine writes into an eight-entry FIFO
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            if (i == 8) check("full_count", int'(fifo_count), 8);
            if (i == 8) check("full_no_ovf", int'(overflow), 0);
        end
        check("ovf_set", int'(overflow), 1);
        check("ovf_count", int'(fifo_count), 8);
        for (int i = 1; i <= 8; i++) begin
            check("drain_char", int'(bus.out_char), i);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_empty", int'(bus.out_valid), 0);
        check("ovf_sticky", int'(overflow), 1);

        // full FIFO with simultaneous read and write
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rw_full_count", int'(fifo_count), 8);
        check("rw_full_ovf", int'(overflow), 0);
        for (int i = 2; i <= 8; i++) begin
            check("rw_drain", int'(bus.out_char), i);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("rw_aa_last", int'(bus.out_char), 8'hAA);
        check("rw_aa_tag", int'(bus.out_last), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // clear wins over a simultaneous write
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_count", int'(fifo_count), 0);
        check("clr_valid", int'(bus.out_valid), 0);
        check("clr_ovf", int'(overflow), 0);
        check("clr_len", int'(msg_len), 0);
        repeat (3) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
            check("clr_no_55", int'(bus.out_valid), 0);
        end

        // err_cnt saturation
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
            cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("err_sat", int'(err_cnt), 255);

        // random traffic against the model
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0));
        end

        // asynchronous reset mid-run with three entries stored
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_rst_count", int'(fifo_count), 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_char", int'(bus.out_char), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_err", int'(err_cnt), 0);
        check("rst_len", int'(msg_len), 0);
        check("rst_done", int'(msg_done), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ciphertext_collector.md
Name: ciphertext_collector

Overview:
- Downstream stage of the per-character encryption block. Captures each registered ciphertext character (Char_ciphertext qualified by C_ready) into a small FIFO.
- Tags the final character of each message and tracks message length and invalid-plaintext events.
- Presents buffered characters to the transmit/output stage over a valid/ready handshake.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, 8, width of msg_len and err_cnt

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
C_ready  input  1  write strobe: Char_ciphertext valid this cycle
Char_ciphertext  input  8  ciphertext character from encryption stage
err_invalid_ptxt  input  1  invalid-plaintext flag from encryption stage
msg_last  input  1  marks current C_ready character as last of message; ignored when C_ready=0
clear  input  1  synchronous flush of FIFO, counters and flags
out_valid  output  1  head entry available
out_char  output  8  head entry character
out_last  output  1  head entry is last of its message
out_ready  input  1  consumer accepts head when out_valid=1
fifo_count  output  $clog2(DEPTH)+1  number of stored entries
overflow  output  1  sticky: a write was dropped because FIFO was full
err_cnt  output  CNT_W  saturating count of err_invalid_ptxt rising edges
msg_len  output  CNT_W  characters written in current/last message, saturating
msg_done  output  1  one-cycle pulse after the last character of a message is written

Behaviour:
- Reset: asynchronous on rst_n=0; all outputs 0, FIFO empty, FSM IDLE, err edge register 0. Reset is effective mid-message; no partial state survives.
- Write event: C_ready=1 at a clk edge. Entry stores {msg_last, Char_ciphertext}.
- Read event: out_valid=1 and out_ready=1 at a clk edge. Head pops.
- FIFO type: first-word-fall-through. out_valid = (fifo_count != 0); out_char and out_last come from the head entry.
- Latency: a write into an empty FIFO is visible on out_valid the next cycle. There is no same-cycle bypass.
- When out_valid=0, out_char=8'h00 and out_last=0.
- Full (fifo_count=DEPTH):
  - Write without read: character dropped, overflow<=1 (sticky until clear/reset), fifo_count unchanged.
  - Simultaneous read and write: both accepted, fifo_count unchanged, no overflow.
- Empty: read not possible (out_valid=0). A write alone increments fifo_count.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- FSM, two states:
  - IDLE: a write with msg_last=0 -> COLLECT, msg_len<=1. A write with msg_last=1 -> stays IDLE, msg_len<=1, msg_done pulses next cycle.
  - COLLECT: a write increments msg_len, saturating at 2^CNT_W-1. A write with msg_last=1 -> IDLE, msg_done=1 for exactly the following cycle.
  - msg_len holds its value in IDLE until the next message starts.
- A dropped write (overflow) still advances the FSM and msg_len, including msg_last termination. Downstream detects the corruption through overflow.
- err_cnt:
  - Increments by 1 on each clk edge where err_invalid_ptxt=1 and its registered previous value=0.
  - Saturates at all-ones. Independent of C_ready.
- clear=1 at a clk edge:
  - fifo_count<=0, pointers<=0, overflow<=0, err_cnt<=0, msg_len<=0, msg_done<=0, FSM<=IDLE.
  - clear has priority over a simultaneous write or read; the write is discarded without setting overflow.
  - The err edge register still samples err_invalid_ptxt.
- No combinational path from C_ready or Char_ciphertext to any output. out_valid, out_char and out_last depend only on registered state.

Test Plan:
1. Assert rst_n=0 mid-run with FIFO holding 3 entries -> immediately out_valid=0, out_char=0, fifo_count=0, overflow=0, err_cnt=0, msg_len=0, msg_done=0.
2. Write 8'h10, 8'h20, 8'h30 (msg_last on 8'h30) with out_ready=0 -> fifo_count=3, msg_len=3, msg_done high one cycle after the 8'h30 write. Then out_ready=1 -> out_char 10, 20, 30 on consecutive cycles, out_last=1 only with 30, then out_valid=0.
3. DEPTH=8, out_ready=0, write 9 chars 8'h01..8'h09 -> after 8: fifo_count=8. After 9th: overflow=1, fifo_count=8. Drain yields 01..08 only, and overflow stays 1.
4. Full FIFO, same-cycle write 8'hAA and read -> fifo_count stays 8, overflow=0. 8'hAA is read last, after the 7 remaining older entries.
5. err_invalid_ptxt high 5 cycles, low 2, high 1, low -> err_cnt=2. Force 300 edges with CNT_W=8 -> err_cnt=255.
6. clear asserted in the same cycle as a write of 8'h55 with 4 entries stored -> next cycle fifo_count=0, out_valid=0, overflow=0, msg_len=0, and 8'h55 is never output.
